pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for an in-order pipeline: scoreboard of in-flight writers, stall/flush/freeze, forward selects.
// Optional feature macro: HAZ_FWD_EN (defined = operand forwarding enabled, only load-use stalls).
module pipe_hazard_ctrl #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16,
  localparam int FSW     = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [AW-1:0]   id_rs1_i,
  input  logic [AW-1:0]   id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic [AW-1:0]   id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_is_load_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_busy_i,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            flush_d_o,
  output logic            flush_e_o,
  output logic            freeze_o,
  output logic [FSW-1:0]  fwd_a_sel_o,
  output logic [FSW-1:0]  fwd_b_sel_o,
  output logic [CNTW-1:0] perf_stall_cnt_o,
  output logic [CNTW-1:0] perf_flush_cnt_o
);

  // Entry k describes the instruction k stages past decode (1 = execute, DEPTH = writeback).
  logic [DEPTH:1] sb_v_q;
  logic [AW-1:0]  sb_rd_q [1:DEPTH];
`ifdef HAZ_FWD_EN
  logic [DEPTH:1] sb_ld_q;
`else
  logic           unused_load_flag;
  assign unused_load_flag = id_is_load_i;
`endif

  logic [FSW-1:0]  fwd_a_q, fwd_a_d;
  logic [FSW-1:0]  fwd_b_q, fwd_b_d;
  logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;
  logic            haz, hit_a, hit_b;
  logic            stall_f, stall_d, flush_d, flush_e, freeze;

  function automatic logic match(input int k, input logic [AW-1:0] r);
    return sb_v_q[k] && (sb_rd_q[k] == r) && (r != '0);
  endfunction

  // Scan oldest to youngest so the youngest matching producer overwrites the select.
  always_comb begin
    haz     = 1'b0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    fwd_a_d = '0;
    fwd_b_d = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      hit_a = id_use_rs1_i && match(k, id_rs1_i);
      hit_b = id_use_rs2_i && match(k, id_rs2_i);
`ifdef HAZ_FWD_EN
      if ((hit_a || hit_b) && sb_ld_q[k] && (k <= LOAD_LAT)) haz = 1'b1;
      if (k <= DEPTH - 1) begin
        if (hit_a) fwd_a_d = FSW'(k);
        if (hit_b) fwd_b_d = FSW'(k);
      end
`else
      if ((hit_a || hit_b) && (k <= DEPTH - 1)) haz = 1'b1;
`endif
    end
    if (!id_valid_i) begin
      haz     = 1'b0;
      fwd_a_d = '0;
      fwd_b_d = '0;
    end
  end

  // id_valid_i qualifies every id_* input; stall_d_o is the only backpressure toward decode.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    freeze  = 1'b0;
    if (rst_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mem_busy_i) begin
      freeze  = 1'b1;
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (ex_branch_taken_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (haz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_v_q <= '0;
      for (int k = 1; k <= DEPTH; k++) sb_rd_q[k] <= '0;
`ifdef HAZ_FWD_EN
      sb_ld_q <= '0;
`endif
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!mem_busy_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v_q[k]  <= sb_v_q[k-1];
        sb_rd_q[k] <= sb_rd_q[k-1];
`ifdef HAZ_FWD_EN
        sb_ld_q[k] <= sb_ld_q[k-1];
`endif
      end
      sb_v_q[1]  <= !flush_e && id_valid_i && id_regwrite_i && (id_rd_i != '0);
      sb_rd_q[1] <= id_rd_i;
`ifdef HAZ_FWD_EN
      sb_ld_q[1] <= id_is_load_i;
`endif
      fwd_a_q <= flush_e ? '0 : fwd_a_d;
      fwd_b_q <= flush_e ? '0 : fwd_b_d;
      if (ex_branch_taken_i) begin
        if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (haz) begin
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_f_o        = stall_f;
  assign stall_d_o        = stall_d;
  assign flush_d_o        = flush_d;
  assign flush_e_o        = flush_e;
  assign freeze_o         = freeze;
  assign fwd_a_sel_o      = fwd_a_q;
  assign fwd_b_sel_o      = fwd_b_q;
  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3, LOAD_LAT=1, narrow counters to reach saturation quickly).
module tb_pipe_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CNTW = 4;
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_BUSY  = 5'b11001;

  logic            clk, rst;
  logic            id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            ex_branch_taken, mem_busy;
  logic            stall_f, stall_d, flush_d, flush_e, freeze;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic [CNTW-1:0] perf_stall_cnt, perf_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.AW(AW), .DEPTH(3), .LOAD_LAT(1), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .ex_branch_taken_i(ex_branch_taken), .mem_busy_i(mem_busy),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_d_o(flush_d),
    .flush_e_o(flush_e), .freeze_o(freeze),
    .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
    .perf_stall_cnt_o(perf_stall_cnt), .perf_flush_cnt_o(perf_flush_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_id(input logic v, input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2,
                          input logic [AW-1:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'b0, stall_f, stall_d, flush_d, flush_e, freeze}, {27'b0, exp});
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    idle();
    tick();
    tick();
    check_ctl("rst_ctl", C_FLUSH);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    idle();

    // Reset state
    do_reset();
    check("rst_fwd_a", 32'(fwd_a_sel), 0);
    check("rst_fwd_b", 32'(fwd_b_sel), 0);
    check("rst_stall_cnt", 32'(perf_stall_cnt), 0);
    check("rst_flush_cnt", 32'(perf_flush_cnt), 0);

    // add x5 ; add x6,x5,x1
    drive_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    check_ctl("t1_producer", C_NONE);
    tick();
    drive_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
`ifdef HAZ_FWD_EN
    check_ctl("t1_consumer", C_NONE);
    tick();
    idle();
    check("t1_fwd_a", 32'(fwd_a_sel), 1);
    check("t1_fwd_b", 32'(fwd_b_sel), 0);
    check("t1_stall_cnt", 32'(perf_stall_cnt), 0);
`else
    check_ctl("t1_stall1", C_STALL);
    tick();
    check_ctl("t1_stall2", C_STALL);
    tick();
    check_ctl("t1_release", C_NONE);
    tick();
    idle();
    check("t1_fwd_a", 32'(fwd_a_sel), 0);
    check("t1_stall_cnt", 32'(perf_stall_cnt), 2);
`endif

    // lw x5 ; add x6,x5
    do_reset();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    drive_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    check_ctl("t2_stall1", C_STALL);
    tick();
`ifdef HAZ_FWD_EN
    check_ctl("t2_release", C_NONE);
    check("t2_bubble_fwd", 32'(fwd_a_sel), 0);
    tick();
    idle();
    check("t2_fwd_a", 32'(fwd_a_sel), 2);
    check("t2_stall_cnt", 32'(perf_stall_cnt), 1);
`else
    check_ctl("t2_stall2", C_STALL);
    tick();
    check_ctl("t2_release", C_NONE);
    tick();
    idle();
    check("t2_fwd_a", 32'(fwd_a_sel), 0);
    check("t2_stall_cnt", 32'(perf_stall_cnt), 2);
`endif

    // Branch beats load-use; busy beats branch, branch acts after release
    do_reset();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    ex_branch_taken = 1'b1;
    drive_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    check_ctl("t3_flush", C_FLUSH);
    tick();
    check("t3_flush_cnt", 32'(perf_flush_cnt), 1);
    check("t3_stall_cnt", 32'(perf_stall_cnt), 0);
    check("t3_fwd_a", 32'(fwd_a_sel), 0);
    mem_busy = 1'b1;
    #1;
    check_ctl("t3_busy_over_branch", C_BUSY);
    tick();
    check("t3_flush_cnt_held", 32'(perf_flush_cnt), 1);
    mem_busy = 1'b0;
    #1;
    check_ctl("t3_branch_after_busy", C_FLUSH);
    tick();
    check("t3_flush_cnt2", 32'(perf_flush_cnt), 2);
    ex_branch_taken = 1'b0;

    // D-cache busy for 3 cycles with a load in sb[1]
    do_reset();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    mem_busy = 1'b1;
    drive_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check_ctl($sformatf("t4_busy%0d", i), C_BUSY);
      check($sformatf("t4_busy_cnt%0d", i), 32'(perf_stall_cnt), 0);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    check_ctl("t4_stall1", C_STALL);
    tick();
`ifdef HAZ_FWD_EN
    check_ctl("t4_release", C_NONE);
    tick();
    idle();
    check("t4_fwd_a", 32'(fwd_a_sel), 2);
    check("t4_stall_cnt", 32'(perf_stall_cnt), 1);
`else
    check_ctl("t4_stall2", C_STALL);
    tick();
    check_ctl("t4_release", C_NONE);
    tick();
    idle();
    check("t4_fwd_a", 32'(fwd_a_sel), 0);
    check("t4_stall_cnt", 32'(perf_stall_cnt), 2);
`endif

    // x0 never hazards; unused source fields never hazard
    do_reset();
    drive_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);
    tick();
    drive_id(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0);
    check_ctl("t5_x0_ctl", C_NONE);
    tick();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    check("t5_x0_fwd", 32'(fwd_a_sel), 0);
    tick();
    drive_id(1, 5'd5, 0, 5'd5, 0, 5'd6, 1, 0);
    check_ctl("t5_unused_src", C_NONE);

    // Reset in the middle of a stall
    do_reset();
    drive_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    drive_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    check_ctl("t6_stall", C_STALL);
    tick();
    check("t6_stall_cnt", 32'(perf_stall_cnt), 1);
    rst = 1'b1;
    #1;
    check_ctl("t6_in_rst", C_FLUSH);
    tick();
    rst = 1'b0;
    #1;
    check_ctl("t6_after_rst", C_NONE);
    check("t6_cnt_cleared", 32'(perf_stall_cnt), 0);

    // Two writers of x7; consumer reads x7 on rs2, youngest producer wins
    do_reset();
    drive_id(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
    tick();
    drive_id(1, 5'd3, 1, 5'd4, 1, 5'd7, 1, 0);
    tick();
    drive_id(1, 5'd1, 1, 5'd7, 1, 5'd8, 1, 0);
`ifdef HAZ_FWD_EN
    check_ctl("t7_no_stall", C_NONE);
    tick();
    idle();
    check("t7_fwd_b", 32'(fwd_b_sel), 1);
    check("t7_fwd_a", 32'(fwd_a_sel), 0);
`else
    check_ctl("t7_stall1", C_STALL);
    tick();
    check_ctl("t7_stall2", C_STALL);
    tick();
    check_ctl("t7_release", C_NONE);
    tick();
    idle();
    check("t7_fwd_b", 32'(fwd_b_sel), 0);
    check("t7_stall_cnt", 32'(perf_stall_cnt), 2);
`endif

    // Flush counter saturates at all-ones
    do_reset();
    ex_branch_taken = 1'b1;
    #1;
    repeat (20) tick();
    check("t8_flush_sat", 32'(perf_flush_cnt), 15);
    check_ctl("t8_flush_ctl", C_FLUSH);
    ex_branch_taken = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
